// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the divider iteration-counter width.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic int iter_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_restoring_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per enabled cycle,
// WIDTH iterations after a load.
module div_restoring_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = iter_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
    end

    // Divider datapath: the dividend register fills with quotient bits as it shifts out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= dividend;
            dvs_r <= divisor;
            cnt_r <= CW'(WIDTH - 1);
        end else if (enable) begin
            if (diff_s[WIDTH] == 1'b0) begin
                rem_r <= diff_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shift_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign last      = enable && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS multiply/divide unit owning HI/LO: single-cycle MULT/MULTU, iterative
// DIV/DIVU with sign fix-up, and direct MTHI/MTLO writes.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sgn_r;
    logic               dz_r;
    logic               neg_q_r;
    logic               neg_rem_r;

    logic               accept_s;
    logic               is_div_s;
    logic               is_sdiv_s;
    logic               rt_zero_s;
    logic               div_load_s;
    logic [WIDTH-1:0]   dvd_abs_s;
    logic [WIDTH-1:0]   dvs_abs_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               last_s;

    // Issue decode and operand magnitudes for the unsigned divider core.
    always_comb begin
        accept_s   = start && (state_r == ST_IDLE);
        is_div_s   = (op == OPW'(OP_DIV)) || (op == OPW'(OP_DIVU));
        is_sdiv_s  = (op == OPW'(OP_DIV));
        rt_zero_s  = (rt_val == {WIDTH{1'b0}});
        div_load_s = accept_s && is_div_s && !rt_zero_s;
        if (is_sdiv_s && rs_val[WIDTH-1]) begin
            dvd_abs_s = -rs_val;
        end else begin
            dvd_abs_s = rs_val;
        end
        if (is_sdiv_s && rt_val[WIDTH-1]) begin
            dvs_abs_s = -rt_val;
        end else begin
            dvs_abs_s = rt_val;
        end
    end

    // Extending to 2*WIDTH makes the low half of an unsigned product correct for both signednesses.
    always_comb begin
        if (sgn_r) begin
            mul_a_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
            mul_b_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
        end else begin
            mul_a_s = {{WIDTH{1'b0}}, a_r};
            mul_b_s = {{WIDTH{1'b0}}, b_r};
        end
        prod_s = mul_a_s * mul_b_s;
    end

    div_restoring_iter #(
        .WIDTH (WIDTH),
        .CW    (iter_cnt_w(WIDTH))
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (div_load_s),
        .enable    (state_r == ST_DIV),
        .dividend  (dvd_abs_s),
        .divisor   (dvs_abs_s),
        .quotient  (quo_s),
        .remainder (rem_s),
        .last      (last_s)
    );

    // Control FSM and architectural HI/LO state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            sgn_r      <= 1'b0;
            dz_r       <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        div_zero_r <= 1'b0;
                        case (op)
                            OPW'(OP_MULT), OPW'(OP_MULTU): begin
                                a_r     <= rs_val;
                                b_r     <= rt_val;
                                sgn_r   <= (op == OPW'(OP_MULT));
                                state_r <= ST_MUL;
                                busy_r  <= 1'b1;
                            end
                            OPW'(OP_DIV), OPW'(OP_DIVU): begin
                                a_r       <= rs_val;
                                dz_r      <= rt_zero_s;
                                neg_q_r   <= is_sdiv_s && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                neg_rem_r <= is_sdiv_s && rs_val[WIDTH-1];
                                state_r   <= rt_zero_s ? ST_FIX : ST_DIV;
                                busy_r    <= 1'b1;
                            end
                            OPW'(OP_MTHI): hi_r <= rs_val;
                            OPW'(OP_MTLO): lo_r <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    {hi_r, lo_r} <= prod_s;
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b1;
                end
                ST_DIV: begin
                    if (last_s) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Magnitude negation also yields the most-negative/-1 overflow result unchanged.
                    if (dz_r) begin
                        lo_r       <= {WIDTH{1'b1}};
                        hi_r       <= a_r;
                        div_zero_r <= 1'b1;
                    end else begin
                        lo_r <= neg_q_r ? -quo_s : quo_s;
                        hi_r <= neg_rem_r ? -rem_s : rem_s;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
